alu_op_server: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_resp_fifo.sv | 77 +++++++
 rtl/alu_op_server.sv | 99 +++++++++
 tb/tb_alu_op_server.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command encoding and response-entry layout for alu_op_server.
// A response entry is packed as {overflow, carryout, zero, result}.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    localparam int FLAG_W = 3;

    typedef struct packed {
        logic overflow;
        logic carryout;
        logic zero;
    } alu_flags_t;

    // Two's-complement overflow of a + b_eff, where b_eff is B for ADD and ~B for SUB.
    function automatic logic add_overflow(input logic a_msb, input logic b_eff_msb,
                                          input logic r_msb);
        return (a_msb == b_eff_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Synchronous DW-bit x DEPTH FIFO with explicit occupancy count.
// Head entry is shown on dout at all times, including stale contents when empty.
module alu_resp_fifo
    import alu_pkg::*;
#(
    parameter int  DW     = 35,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic [FILL_W-1:0] fill,
    output logic              full,
    output logic              empty
);

    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (fill_q == FILL_W'(DEPTH));
    assign empty   = (fill_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign fill    = fill_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            // NOTE: storage is cleared on reset because the empty FIFO still drives the head entry to the outputs, which must read as zero.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_op_server.sv
// Handshaked ALU request server: computes each accepted request combinationally
// and queues {overflow, carryout, zero, result} in a response FIFO.
module alu_op_server
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_command,
    input  logic [WIDTH-1:0]         req_operandA,
    input  logic [WIDTH-1:0]         req_operandB,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     resp_zero,
    output logic                     resp_carryout,
    output logic                     resp_overflow,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int ENTRY_W = WIDTH + FLAG_W;
    localparam int MSB     = WIDTH - 1;

    logic [WIDTH:0]       sum_add;
    logic [WIDTH:0]       sum_sub;
    logic                 ovf_add;
    logic                 ovf_sub;
    logic [WIDTH-1:0]     result;
    alu_flags_t           flags;
    logic [ENTRY_W-1:0]   head;
    alu_flags_t           head_flags;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign sum_add = {1'b0, req_operandA} + {1'b0, req_operandB};
    assign sum_sub = {1'b0, req_operandA} + {1'b0, ~req_operandB} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf_add = add_overflow(req_operandA[MSB], req_operandB[MSB], sum_add[MSB]);
    assign ovf_sub = add_overflow(req_operandA[MSB], ~req_operandB[MSB], sum_sub[MSB]);

    always_comb begin
        result         = '0;
        flags.carryout = 1'b0;
        flags.overflow = 1'b0;
        case (alu_cmd_e'(req_command))
            ALU_ADD: begin
                result         = sum_add[WIDTH-1:0];
                flags.carryout = sum_add[WIDTH];
                flags.overflow = ovf_add;
            end
            ALU_SUB: begin
                result         = sum_sub[WIDTH-1:0];
                flags.carryout = sum_sub[WIDTH];
                flags.overflow = ovf_sub;
            end
            // Signed less-than: subtract sign corrected by subtract overflow.
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, sum_sub[MSB] ^ ovf_sub};
            ALU_XOR:  result = req_operandA ^ req_operandB;
            ALU_AND:  result = req_operandA & req_operandB;
            ALU_NAND: result = ~(req_operandA & req_operandB);
            ALU_NOR:  result = ~(req_operandA | req_operandB);
            ALU_OR:   result = req_operandA | req_operandB;
            default:  result = '0;
        endcase
        flags.zero = (result == '0);
    end

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign resp_valid = !empty;
    assign pop       = resp_valid && resp_ready;

    alu_resp_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({flags, result}),
        .dout    (head),
        .fill    (fill),
        .full    (full),
        .empty   (empty)
    );

    assign head_flags    = alu_flags_t'(head[WIDTH +: FLAG_W]);
    assign resp_result   = head[WIDTH-1:0];
    assign resp_zero     = head_flags.zero;
    assign resp_carryout = head_flags.carryout;
    assign resp_overflow = head_flags.overflow;

endmodule

// File: tb/tb_alu_op_server.sv
// Directed bench for alu_op_server: ALU results/flags, FIFO backpressure,
// wrap-around ordering under simultaneous push/pop, and async reset.
module tb_alu_op_server;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_command;
    logic [WIDTH-1:0]  req_operandA;
    logic [WIDTH-1:0]  req_operandB;
    logic              resp_valid;
    logic              resp_ready;
    logic [WIDTH-1:0]  resp_result;
    logic              resp_zero;
    logic              resp_carryout;
    logic              resp_overflow;
    logic [2:0]        fill;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [$];

    alu_op_server #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_command   (req_command),
        .req_operandA  (req_operandA),
        .req_operandB  (req_operandB),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_zero     (resp_zero),
        .resp_carryout (resp_carryout),
        .resp_overflow (resp_overflow),
        .fill          (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] cmd, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid    = 1'b1;
        req_command  = cmd;
        req_operandA = a;
        req_operandB = b;
    endtask

    // One request into an empty FIFO with resp_ready high: visible one edge later, gone the next.
    task automatic one_op(input string tag, input logic [2:0] cmd,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] r, input logic z, input logic c, input logic o);
        resp_ready = 1'b1;
        drive(cmd, a, b);
        tick();
        req_valid = 1'b0;
        check({tag, "_valid"}, resp_valid, 1'b1);
        check({tag, "_result"}, resp_result, r);
        check({tag, "_flags"}, {resp_zero, resp_carryout, resp_overflow}, {z, c, o});
        check({tag, "_fill1"}, fill, 3'd1);
        tick();
        check({tag, "_fill0"}, fill, 3'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_command  = 3'd0;
        req_operandA = '0;
        req_operandB = '0;
        resp_ready   = 1'b0;
        #3;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_fill", fill, 3'd0);
        check("rst_result", resp_result, 32'h0);
        check("rst_flags", {resp_zero, resp_carryout, resp_overflow}, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;

        // Arithmetic and logic results with flags {zero, carryout, overflow}.
        one_op("add_0_m1",  3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        one_op("sub_eq",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 0);
        one_op("add_ovf",   3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1);
        one_op("add_carry", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0);
        one_op("sub_borrow",3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0);
        one_op("sub_ovf",   3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1);
        one_op("slt_neg",   3'd3, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'h0000_0001, 0, 0, 0);
        one_op("slt_ovf",   3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0);
        one_op("xor",       3'd2, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'hFFC0_0000, 0, 0, 0);
        one_op("and",       3'd4, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'h003F_FFFF, 0, 0, 0);
        one_op("nand",      3'd5, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'hFFC0_0000, 0, 0, 0);
        one_op("nor",       3'd6, 32'hFFFF_FFFF, 32'h003F_FFFF, 32'h0000_0000, 1, 0, 0);
        one_op("or",        3'd7, 32'hDFFF_FFFF, 32'h003F_FFFF, 32'hDFFF_FFFF, 0, 0, 0);

        // Fill to DEPTH with consumer stalled, then drain while a fifth request waits.
        resp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(3'd0, WIDTH'(i), WIDTH'(i));
            tick();
        end
        check("full_fill", fill, 3'd4);
        check("full_req_ready", req_ready, 1'b0);
        check("full_head", resp_result, 32'd2);
        drive(3'd0, 32'd5, 32'd5);
        tick();
        check("held_fill", fill, 3'd4);
        check("held_head_stable", resp_result, 32'd2);
        resp_ready = 1'b1;
        tick();
        check("pop1_fill", fill, 3'd3);
        check("pop1_req_ready", req_ready, 1'b1);
        check("pop1_head", resp_result, 32'd4);
        tick();
        req_valid = 1'b0;
        check("pop2_fill", fill, 3'd3);
        check("pop2_head", resp_result, 32'd6);
        tick();
        check("pop3_head", resp_result, 32'd8);
        tick();
        check("pop4_head", resp_result, 32'd10);
        check("pop4_fill", fill, 3'd1);
        tick();
        check("drain_valid", resp_valid, 1'b0);

        // Hold fill at 2 with simultaneous push/pop across pointer wrap.
        resp_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            drive(3'd0, WIDTH'(k), WIDTH'(3 * k));
            exp_q.push_back(WIDTH'(4 * k));
            tick();
        end
        req_valid = 1'b0;
        check("pp_start_fill", fill, 3'd2);
        resp_ready = 1'b1;
        for (int k = 3; k <= 12; k++) begin
            drive(3'd0, WIDTH'(k), WIDTH'(3 * k));
            exp_q.push_back(WIDTH'(4 * k));
            check("pp_head", resp_result, exp_q.pop_front());
            tick();
            check("pp_fill", fill, 3'd2);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("pp_drain_head", resp_result, exp_q.pop_front());
            tick();
        end
        check("pp_empty", fill, 3'd0);

        // Asynchronous reset mid-cycle with three entries queued.
        resp_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(3'd7, 32'hA500_0000, WIDTH'(k));
            tick();
        end
        req_valid = 1'b0;
        check("pre_rst_fill", fill, 3'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 1'b0);
        check("arst_fill", fill, 3'd0);
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_result", resp_result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        one_op("post_rst_add", 3'd0, 32'd5, 32'd6, 32'd11, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
